// File: rtl/axi4_lite_router.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_router
// Purpose  : One AXI4-Lite master to NUM_SLAVES AXI4-Lite slaves. Decodes
//            the AW/AR address against SLV_BASE/SLV_MASK and forwards the
//            transaction to the lowest-index matching slave. Unmapped
//            addresses are completed locally with DECERR. There is one
//            outstanding write and one outstanding read, and the write and
//            read paths are fully independent.
// Ports    : ACLK, ARESETn          clock, async active-low reset
//            S_AW*/S_W*/S_B*        write channels from the master
//            S_AR*/S_R*             read channels from the master
//            M_*VALID/M_*READY      one bit per slave (one-hot while active)
//            M_AWADDR/M_WDATA/...   shared, driven from latched registers
//            M_BRESP/M_RDATA/M_RRESP packed per-slave response slices
// Revision : 1.0  initial release
// ============================================================================
module axi4_lite_router #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    // write channels from the master
    input  logic                             S_AWVALID,
    output logic                             S_AWREADY,
    input  logic [ADDR_WIDTH-1:0]            S_AWADDR,
    input  logic [2:0]                       S_AWPROT,
    input  logic                             S_WVALID,
    output logic                             S_WREADY,
    input  logic [DATA_WIDTH-1:0]            S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]          S_WSTRB,
    output logic                             S_BVALID,
    input  logic                             S_BREADY,
    output logic [1:0]                       S_BRESP,
    // read channels from the master
    input  logic                             S_ARVALID,
    output logic                             S_ARREADY,
    input  logic [ADDR_WIDTH-1:0]            S_ARADDR,
    input  logic [2:0]                       S_ARPROT,
    output logic                             S_RVALID,
    input  logic                             S_RREADY,
    output logic [DATA_WIDTH-1:0]            S_RDATA,
    output logic [1:0]                       S_RRESP,
    // slave-side write channels
    output logic [NUM_SLAVES-1:0]            M_AWVALID,
    input  logic [NUM_SLAVES-1:0]            M_AWREADY,
    output logic [ADDR_WIDTH-1:0]            M_AWADDR,
    output logic [2:0]                       M_AWPROT,
    output logic [NUM_SLAVES-1:0]            M_WVALID,
    input  logic [NUM_SLAVES-1:0]            M_WREADY,
    output logic [DATA_WIDTH-1:0]            M_WDATA,
    output logic [DATA_WIDTH/8-1:0]          M_WSTRB,
    input  logic [NUM_SLAVES-1:0]            M_BVALID,
    output logic [NUM_SLAVES-1:0]            M_BREADY,
    input  logic [2*NUM_SLAVES-1:0]          M_BRESP,
    // slave-side read channels
    output logic [NUM_SLAVES-1:0]            M_ARVALID,
    input  logic [NUM_SLAVES-1:0]            M_ARREADY,
    output logic [ADDR_WIDTH-1:0]            M_ARADDR,
    output logic [2:0]                       M_ARPROT,
    input  logic [NUM_SLAVES-1:0]            M_RVALID,
    output logic [NUM_SLAVES-1:0]            M_RREADY,
    input  logic [DATA_WIDTH*NUM_SLAVES-1:0] M_RDATA,
    input  logic [2*NUM_SLAVES-1:0]          M_RRESP
);

    localparam int c_sel_w  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_strb_w = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0, W_DATA = 3'd1, W_FWD = 3'd2, W_ERR = 3'd3, W_RESP = 3'd4
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0, R_FWD = 2'd1, R_ERR = 2'd2, R_RESP = 2'd3
    } rstate_t;

    // Returns {hit, sel}. Scanning downwards lets the lowest matching index
    // overwrite any higher one, so overlapping windows resolve to slave 0 first.
    function automatic logic [c_sel_w:0] f_decode(input logic [ADDR_WIDTH-1:0] addr);
        logic                 hit;
        logic [c_sel_w-1:0]   sel;
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit = 1'b1;
                sel = c_sel_w'(i);
            end
        end
        return {hit, sel};
    endfunction

    wstate_t                 r_wstate, w_wstate_next;
    rstate_t                 r_rstate, w_rstate_next;
    logic                    r_rst_done;
    logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
    logic [2:0]              r_awprot, r_arprot;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_strb_w-1:0]     r_wstrb;
    logic [c_sel_w-1:0]      r_wsel, r_rsel;
    logic                    r_aw_pend, r_w_pend;
    logic [c_sel_w:0]        w_wdec, w_rdec;

    // Write decode uses the address already latched in W_IDLE; read decode
    // uses the address being accepted, which is the value latched that cycle.
    assign w_wdec = f_decode(r_awaddr);
    assign w_rdec = f_decode(S_ARADDR);

    assign M_AWADDR = r_awaddr;
    assign M_AWPROT = r_awprot;
    assign M_WDATA  = r_wdata;
    assign M_WSTRB  = r_wstrb;
    assign M_ARADDR = r_araddr;
    assign M_ARPROT = r_arprot;

    // Keeps the idle READYs low while reset is asserted and until the
    // first clock edge after release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rst_done <= 1'b0;
        else          r_rst_done <= 1'b1;
    end

    // ---------------------------------------------------------------- write
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_wstate <= W_IDLE;
        else          r_wstate <= w_wstate_next;
    end

    always_comb begin
        w_wstate_next = r_wstate;
        S_AWREADY     = 1'b0;
        S_WREADY      = 1'b0;
        S_BVALID      = 1'b0;
        S_BRESP       = 2'b00;
        M_AWVALID     = '0;
        M_WVALID      = '0;
        M_BREADY      = '0;
        case (r_wstate)
            W_IDLE: begin
                S_AWREADY = r_rst_done;
                if (S_AWVALID && r_rst_done) w_wstate_next = W_DATA;
            end
            W_DATA: begin
                S_WREADY = 1'b1;
                if (S_WVALID) w_wstate_next = w_wdec[c_sel_w] ? W_FWD : W_ERR;
            end
            W_FWD: begin
                M_AWVALID[r_wsel] = r_aw_pend;
                M_WVALID[r_wsel]  = r_w_pend;
                // AW and W retire independently; leave once neither is pending.
                if ((!r_aw_pend || M_AWREADY[r_wsel]) && (!r_w_pend || M_WREADY[r_wsel]))
                    w_wstate_next = W_RESP;
            end
            W_RESP: begin
                S_BVALID         = M_BVALID[r_wsel];
                S_BRESP          = M_BRESP[r_wsel*2 +: 2];
                M_BREADY[r_wsel] = S_BREADY;
                if (M_BVALID[r_wsel] && S_BREADY) w_wstate_next = W_IDLE;
            end
            W_ERR: begin
                S_BVALID = 1'b1;
                S_BRESP  = 2'b11;
                if (S_BREADY) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awaddr  <= '0;
            r_awprot  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wsel    <= '0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else begin
            if (r_wstate == W_IDLE && S_AWVALID && S_AWREADY) begin
                r_awaddr <= S_AWADDR;
                r_awprot <= S_AWPROT;
            end
            if (r_wstate == W_DATA && S_WVALID) begin
                r_wdata   <= S_WDATA;
                r_wstrb   <= S_WSTRB;
                r_wsel    <= w_wdec[c_sel_w-1:0];
                r_aw_pend <= 1'b1;
                r_w_pend  <= 1'b1;
            end
            if (r_wstate == W_FWD) begin
                if (M_AWREADY[r_wsel]) r_aw_pend <= 1'b0;
                if (M_WREADY[r_wsel])  r_w_pend  <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- read
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_next;
    end

    always_comb begin
        w_rstate_next = r_rstate;
        S_ARREADY     = 1'b0;
        S_RVALID      = 1'b0;
        S_RDATA       = '0;
        S_RRESP       = 2'b00;
        M_ARVALID     = '0;
        M_RREADY      = '0;
        case (r_rstate)
            R_IDLE: begin
                S_ARREADY = r_rst_done;
                if (S_ARVALID && r_rst_done) w_rstate_next = w_rdec[c_sel_w] ? R_FWD : R_ERR;
            end
            R_FWD: begin
                M_ARVALID[r_rsel] = 1'b1;
                if (M_ARREADY[r_rsel]) w_rstate_next = R_RESP;
            end
            R_RESP: begin
                S_RVALID         = M_RVALID[r_rsel];
                S_RDATA          = M_RDATA[r_rsel*DATA_WIDTH +: DATA_WIDTH];
                S_RRESP          = M_RRESP[r_rsel*2 +: 2];
                M_RREADY[r_rsel] = S_RREADY;
                if (M_RVALID[r_rsel] && S_RREADY) w_rstate_next = R_IDLE;
            end
            R_ERR: begin
                S_RVALID = 1'b1;
                S_RRESP  = 2'b11;
                if (S_RREADY) w_rstate_next = R_IDLE;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_araddr <= '0;
            r_arprot <= '0;
            r_rsel   <= '0;
        end else if (r_rstate == R_IDLE && S_ARVALID && S_ARREADY) begin
            r_araddr <= S_ARADDR;
            r_arprot <= S_ARPROT;
            r_rsel   <= w_rdec[c_sel_w-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_router
// Purpose  : Directed self-checking bench for axi4_lite_router with two
//            behavioural slaves (slave 0 at 0x0xxx_xxxx, slave 1 at
//            0x1xxx_xxxx) plus a second router instance with an overlapping
//            map to check lowest-index priority.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_router;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // master side
    logic        S_AWVALID = 0, S_WVALID = 0, S_BREADY = 0, S_ARVALID = 0, S_RREADY = 0;
    logic [31:0] S_AWADDR = 0, S_WDATA = 0, S_ARADDR = 0;
    logic [3:0]  S_WSTRB = 0;
    logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
    logic [1:0]  S_BRESP, S_RRESP;
    logic [31:0] S_RDATA;
    // slave side
    logic [1:0]  M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
    wire  [1:0]  M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID;
    wire  [3:0]  M_BRESP, M_RRESP;
    wire  [63:0] M_RDATA;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
    logic [3:0]  M_WSTRB;
    logic [2:0]  M_AWPROT, M_ARPROT;

    int         aw_delay [2] = '{0, 0};
    logic [1:0] slv0_bresp   = 2'b00;

    axi4_lite_router #(
        .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SLV_BASE({32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK({32'hF000_0000, 32'hF000_0000})
    ) u_dut (
        .ACLK(clk), .ARESETn(rst_n),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWPROT(3'b000),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR), .S_ARPROT(3'b000),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP)
    );

    // Second instance: slave 1 matches every address, so priority decides.
    // Its slaves never accept, which parks it in the forwarding state.
    logic        ov_awvalid = 0, ov_wvalid = 0;
    logic [31:0] ov_awaddr = 0;
    logic        ov_awready, ov_wready, ov_bvalid, ov_arready, ov_rvalid;
    logic [1:0]  ov_bresp, ov_rresp;
    logic [31:0] ov_rdata, ov_m_awaddr, ov_m_wdata, ov_m_araddr;
    logic [1:0]  ov_m_awvalid, ov_m_wvalid, ov_m_bready, ov_m_arvalid, ov_m_rready;
    logic [3:0]  ov_m_wstrb;
    logic [2:0]  ov_m_awprot, ov_m_arprot;

    axi4_lite_router #(
        .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SLV_BASE({32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK({32'h0000_0000, 32'hF000_0000})
    ) u_dut_ov (
        .ACLK(clk), .ARESETn(rst_n),
        .S_AWVALID(ov_awvalid), .S_AWREADY(ov_awready), .S_AWADDR(ov_awaddr), .S_AWPROT(3'b000),
        .S_WVALID(ov_wvalid), .S_WREADY(ov_wready), .S_WDATA(32'h0BAD_F00D), .S_WSTRB(4'hF),
        .S_BVALID(ov_bvalid), .S_BREADY(1'b1), .S_BRESP(ov_bresp),
        .S_ARVALID(1'b0), .S_ARREADY(ov_arready), .S_ARADDR(32'h0), .S_ARPROT(3'b000),
        .S_RVALID(ov_rvalid), .S_RREADY(1'b1), .S_RDATA(ov_rdata), .S_RRESP(ov_rresp),
        .M_AWVALID(ov_m_awvalid), .M_AWREADY(2'b00), .M_AWADDR(ov_m_awaddr), .M_AWPROT(ov_m_awprot),
        .M_WVALID(ov_m_wvalid), .M_WREADY(2'b00), .M_WDATA(ov_m_wdata), .M_WSTRB(ov_m_wstrb),
        .M_BVALID(2'b00), .M_BREADY(ov_m_bready), .M_BRESP(4'h0),
        .M_ARVALID(ov_m_arvalid), .M_ARREADY(2'b00), .M_ARADDR(ov_m_araddr), .M_ARPROT(ov_m_arprot),
        .M_RVALID(2'b00), .M_RREADY(ov_m_rready), .M_RDATA(64'h0), .M_RRESP(4'h0)
    );

    // Behavioural slaves: AWREADY after aw_delay cycles of AWVALID, W and AR
    // accepted at once, B issued after both AW and W, R one cycle after AR.
    for (genvar i = 0; i < 2; i++) begin : g_slv
        int          aw_cnt, awhs, awv_cyc, wv_cyc;
        logic        aw_got, w_got, bv, rv;
        logic [31:0] rd;
        logic [31:0] mem [16];
        wire         aw_hs = M_AWVALID[i] && M_AWREADY[i];
        wire         w_hs  = M_WVALID[i] && M_WREADY[i];
        assign M_AWREADY[i]         = M_AWVALID[i] && (aw_cnt >= aw_delay[i]);
        assign M_WREADY[i]          = M_WVALID[i];
        assign M_ARREADY[i]         = M_ARVALID[i];
        assign M_BVALID[i]          = bv;
        assign M_BRESP[2*i +: 2]    = (i == 0) ? slv0_bresp : 2'b00;
        assign M_RVALID[i]          = rv;
        assign M_RDATA[32*i +: 32]  = rd;
        assign M_RRESP[2*i +: 2]    = 2'b00;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                aw_cnt <= 0; aw_got <= 0; w_got <= 0; bv <= 0; rv <= 0; rd <= 0;
            end else begin
                aw_cnt  <= (M_AWVALID[i] && !M_AWREADY[i]) ? aw_cnt + 1 : 0;
                awv_cyc <= awv_cyc + (M_AWVALID[i] ? 1 : 0);
                wv_cyc  <= wv_cyc + (M_WVALID[i] ? 1 : 0);
                if (aw_hs) begin aw_got <= 1; awhs <= awhs + 1; end
                if (w_hs) w_got <= 1;
                if (bv && M_BREADY[i]) bv <= 0;
                else if (!bv && (aw_got || aw_hs) && (w_got || w_hs)) begin
                    bv <= 1; aw_got <= 0; w_got <= 0;
                    for (int b = 0; b < 4; b++)
                        if (M_WSTRB[b]) mem[M_AWADDR[5:2]][8*b +: 8] <= M_WDATA[8*b +: 8];
                end
                if (rv && M_RREADY[i]) rv <= 0;
                else if (M_ARVALID[i] && M_ARREADY[i]) begin rv <= 1; rd <= mem[M_ARADDR[5:2]]; end
            end
        end
        initial begin awhs = 0; awv_cyc = 0; wv_cyc = 0; end
    end

    // Monitor: forwarded-valid cycles, master B handshakes, payload stability.
    int w_fwd_cyc = 0, r_fwd_cyc = 0, b_hs = 0, stab_err = 0;
    logic        awv_prev = 0, wv_prev = 0;
    logic [31:0] aw_prev = 0, wd_prev = 0;
    always @(posedge clk) begin
        if (|M_AWVALID && awv_prev && M_AWADDR !== aw_prev) stab_err++;
        if (|M_WVALID && wv_prev && M_WDATA !== wd_prev) stab_err++;
        awv_prev = |M_AWVALID; aw_prev = M_AWADDR;
        wv_prev  = |M_WVALID;  wd_prev = M_WDATA;
        if (|M_AWVALID || |M_WVALID) w_fwd_cyc++;
        if (|M_ARVALID) r_fwd_cyc++;
        if (S_BVALID && S_BREADY) b_hs++;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic timeout(input string what);
        checks++; failures++;
        $display("FAIL %s: timeout waiting for handshake", what);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int hold, output logic [1:0] resp, output logic stable);
        int n;
        resp = 2'bxx; stable = 1'b1;
        S_AWADDR = a; S_AWVALID = 1;
        n = 0; while (!S_AWREADY && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("wr_aw"); S_AWVALID = 0; return; end
        tick; S_AWVALID = 0;
        S_WDATA = d; S_WSTRB = s; S_WVALID = 1;
        n = 0; while (!S_WREADY && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("wr_w"); S_WVALID = 0; return; end
        tick; S_WVALID = 0;
        n = 0; while (!S_BVALID && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("wr_b"); return; end
        resp = S_BRESP;
        for (int k = 0; k < hold; k++) begin
            tick;
            if (S_BVALID !== 1'b1 || S_BRESP !== resp) stable = 1'b0;
        end
        S_BREADY = 1; tick; S_BREADY = 0;
    endtask

    task automatic rd(input logic [31:0] a, input int hold,
                      output logic [31:0] data, output logic [1:0] resp, output logic stable);
        int n;
        data = 'x; resp = 2'bxx; stable = 1'b1;
        S_ARADDR = a; S_ARVALID = 1;
        n = 0; while (!S_ARREADY && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("rd_ar"); S_ARVALID = 0; return; end
        tick; S_ARVALID = 0;
        n = 0; while (!S_RVALID && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("rd_r"); return; end
        data = S_RDATA; resp = S_RRESP;
        for (int k = 0; k < hold; k++) begin
            tick;
            if (S_RVALID !== 1'b1 || S_RDATA !== data || S_RRESP !== resp) stable = 1'b0;
        end
        S_RREADY = 1; tick; S_RREADY = 0;
    endtask

    task automatic test_reset;
        #2 rst_n = 0;
        #10;
        checks++;
        if ({S_AWREADY, S_ARREADY, S_BVALID, S_RVALID} !== 4'b0000) begin
            failures++; $display("FAIL reset_slave_side: got %b want 0000", {S_AWREADY, S_ARREADY, S_BVALID, S_RVALID});
        end
        checks++;
        if ({M_AWVALID, M_WVALID, M_ARVALID} !== 6'b0) begin
            failures++; $display("FAIL reset_master_side: got %b want 000000", {M_AWVALID, M_WVALID, M_ARVALID});
        end
        @(negedge clk) rst_n = 1;
        tick; tick;
        checks++;
        if ({S_AWREADY, S_ARREADY} !== 2'b11) begin
            failures++; $display("FAIL reset_release_ready: got %b want 11", {S_AWREADY, S_ARREADY});
        end
    endtask

    task automatic test_route_write_read;
        logic [1:0] resp; logic st; logic [31:0] d; int a0, a1, v0;
        a0 = g_slv[0].awhs; a1 = g_slv[1].awhs; v0 = g_slv[0].awv_cyc + g_slv[0].wv_cyc;
        wr(32'h1000_0004, 32'hA5A5_5A5A, 4'hF, 0, resp, st);
        checks++;
        if (resp !== 2'b00) begin failures++; $display("FAIL route_bresp: got %b want 00", resp); end
        checks++;
        if (g_slv[1].awhs - a1 != 1 || g_slv[0].awhs - a0 != 0) begin
            failures++; $display("FAIL route_aw_target: s0=%0d s1=%0d want s0=0 s1=1", g_slv[0].awhs - a0, g_slv[1].awhs - a1);
        end
        checks++;
        if (g_slv[0].awv_cyc + g_slv[0].wv_cyc - v0 != 0) begin
            failures++; $display("FAIL route_s0_quiet: slave0 valid cycles=%0d want 0", g_slv[0].awv_cyc + g_slv[0].wv_cyc - v0);
        end
        rd(32'h1000_0004, 0, d, resp, st);
        checks++;
        if (d !== 32'hA5A5_5A5A || resp !== 2'b00) begin
            failures++; $display("FAIL route_readback: got %h/%b want a5a55a5a/00", d, resp);
        end
    endtask

    task automatic test_decerr;
        logic [1:0] resp; logic st; logic [31:0] d; int wf, rf;
        wf = w_fwd_cyc; rf = r_fwd_cyc;
        wr(32'h2000_0000, 32'h1111_2222, 4'hF, 0, resp, st);
        checks++;
        if (resp !== 2'b11) begin failures++; $display("FAIL decerr_bresp: got %b want 11", resp); end
        rd(32'h2000_0000, 0, d, resp, st);
        checks++;
        if (d !== 32'h0 || resp !== 2'b11) begin
            failures++; $display("FAIL decerr_read: got %h/%b want 00000000/11", d, resp);
        end
        checks++;
        if (w_fwd_cyc != wf || r_fwd_cyc != rf) begin
            failures++; $display("FAIL decerr_no_forward: wcyc=%0d rcyc=%0d want 0 0", w_fwd_cyc - wf, r_fwd_cyc - rf);
        end
    endtask

    task automatic test_aw_stall;
        logic [1:0] resp; logic st; int av, wv, bh, se;
        aw_delay[0] = 3; slv0_bresp = 2'b10;
        av = g_slv[0].awv_cyc; wv = g_slv[0].wv_cyc; bh = b_hs; se = stab_err;
        wr(32'h0000_0008, 32'h1234_5678, 4'hF, 0, resp, st);
        checks++;
        if (resp !== 2'b10) begin failures++; $display("FAIL stall_bresp_pass: got %b want 10", resp); end
        checks++;
        if (g_slv[0].awv_cyc - av != 4 || g_slv[0].wv_cyc - wv != 1) begin
            failures++; $display("FAIL stall_valid_cycles: aw=%0d w=%0d want aw=4 w=1", g_slv[0].awv_cyc - av, g_slv[0].wv_cyc - wv);
        end
        checks++;
        if (b_hs - bh != 1 || stab_err != se) begin
            failures++; $display("FAIL stall_single_b_stable: b=%0d stab_err=%0d want 1 0", b_hs - bh, stab_err - se);
        end
        checks++;
        if (g_slv[0].mem[2] !== 32'h1234_5678) begin
            failures++; $display("FAIL stall_data: got %h want 12345678", g_slv[0].mem[2]);
        end
        aw_delay[0] = 0; slv0_bresp = 2'b00;
    endtask

    task automatic test_back_to_back_concurrent;
        logic [1:0] wresp, rresp; logic wst, rst; logic [31:0] d; int a1;
        a1 = g_slv[1].awhs;
        fork
            wr(32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 5, wresp, wst);
            rd(32'h1000_0004, 5, d, rresp, rst);
        join
        checks++;
        if (wresp !== 2'b00 || wst !== 1'b1) begin
            failures++; $display("FAIL conc_write_resp: got %b stable=%b want 00 stable=1", wresp, wst);
        end
        checks++;
        if (d !== 32'hA5A5_5A5A || rresp !== 2'b00 || rst !== 1'b1) begin
            failures++; $display("FAIL conc_read_resp: got %h/%b stable=%b want a5a55a5a/00 stable=1", d, rresp, rst);
        end
        checks++;
        if (g_slv[0].mem[3] !== 32'hDEAD_BEEF || g_slv[1].awhs != a1) begin
            failures++; $display("FAIL conc_crosstalk: s0mem=%h s1aw=%0d want deadbeef 0", g_slv[0].mem[3], g_slv[1].awhs - a1);
        end
    endtask

    task automatic test_overlap;
        int n;
        ov_awaddr = 32'h0000_0010; ov_awvalid = 1;
        n = 0; while (!ov_awready && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("ov_aw"); ov_awvalid = 0; return; end
        tick; ov_awvalid = 0; ov_wvalid = 1;
        n = 0; while (!ov_wready && n < 50) begin tick; n++; end
        if (n >= 50) begin timeout("ov_w"); ov_wvalid = 0; return; end
        tick; ov_wvalid = 0; tick;
        checks++;
        if (ov_m_awvalid !== 2'b01 || ov_m_wvalid !== 2'b01) begin
            failures++; $display("FAIL overlap_priority: aw=%b w=%b want 01 01", ov_m_awvalid, ov_m_wvalid);
        end
    endtask

    task automatic test_reset_mid;
        int n; logic bad; logic [1:0] resp; logic st;
        aw_delay[0] = 10;
        S_AWADDR = 32'h0000_0004; S_AWVALID = 1;
        n = 0; while (!S_AWREADY && n < 50) begin tick; n++; end
        tick; S_AWVALID = 0; S_WDATA = 32'h5555_AAAA; S_WSTRB = 4'hF; S_WVALID = 1;
        n = 0; while (!S_WREADY && n < 50) begin tick; n++; end
        tick; S_WVALID = 0;
        checks++;
        if (M_AWVALID !== 2'b01) begin failures++; $display("FAIL rstmid_in_fwd: aw=%b want 01", M_AWVALID); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, ov_m_awvalid} !== 12'b0) begin
            failures++; $display("FAIL rstmid_m_async: got %b want 0", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, ov_m_awvalid});
        end
        checks++;
        if ({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID} !== 5'b0) begin
            failures++; $display("FAIL rstmid_s_async: got %b want 00000", {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID});
        end
        aw_delay[0] = 0;
        @(negedge clk); @(negedge clk) rst_n = 1;
        tick; tick;
        checks++;
        if ({S_AWREADY, S_ARREADY} !== 2'b11) begin
            failures++; $display("FAIL rstmid_ready_after: got %b want 11", {S_AWREADY, S_ARREADY});
        end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin tick; if (S_BVALID !== 1'b0) bad = 1'b1; end
        checks++;
        if (bad) begin failures++; $display("FAIL rstmid_stray_b: BVALID seen after reset want none"); end
        wr(32'h1000_0008, 32'h0F0F_0F0F, 4'hF, 0, resp, st);
        checks++;
        if (resp !== 2'b00 || g_slv[1].mem[2] !== 32'h0F0F_0F0F) begin
            failures++; $display("FAIL rstmid_resume: resp=%b mem=%h want 00 0f0f0f0f", resp, g_slv[1].mem[2]);
        end
    endtask

    initial begin
        test_reset;
        test_route_write_read;
        test_decerr;
        test_aw_stall;
        test_back_to_back_concurrent;
        test_overlap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
